param_micro_cpu: RTL and testbench

- Parametrised successor to the team's 8-bit microprogrammed teaching CPU.
- Single clock domain with an explicit state register; no derived T1/T2 phase clocks.
- Configurable data width and program-memory depth, a wider ISA (arithmetic, immediates, jumps), a flag register, and vectored maskable interrupts with return.
- Sits at top level with a program-load port and IN/OUT device ports.

---
 rtl/param_micro_cpu.sv | 279 +++++++++++++++++++++++++++
 tb/tb_param_micro_cpu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_micro_cpu.sv
// ============================================================================
// Module   : param_micro_cpu
// Desc     : Parametrised single-clock microprogrammed CPU with flags, jumps and
//            vectored maskable interrupts. Define SHIFT_OPS_EN to add SHL/SHR.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module param_micro_cpu #(
  parameter int          DW      = 8,
  parameter int          AW      = 4,
  parameter int unsigned INT_VEC = 4'hE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic          interrupt,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          int_ack,
  output logic [AW-1:0] pc,
  output logic [7:0]    ir,
  output logic          halted,
  output logic          zflag,
  output logic          cflag
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fetch = 3'd1;
  localparam logic [2:0] c_st_exec  = 3'd2;
  localparam logic [2:0] c_st_opnd  = 3'd3;
  localparam logic [2:0] c_st_int   = 3'd4;
  localparam logic [2:0] c_st_halt  = 3'd5;

  localparam logic [3:0] c_op_in   = 4'h0;
  localparam logic [3:0] c_op_out  = 4'h1;
  localparam logic [3:0] c_op_mov  = 4'h2;
  localparam logic [3:0] c_op_add  = 4'h3;
  localparam logic [3:0] c_op_sub  = 4'h4;
  localparam logic [3:0] c_op_and  = 4'h5;
  localparam logic [3:0] c_op_ldi  = 4'h6;
  localparam logic [3:0] c_op_jmp  = 4'h7;
  localparam logic [3:0] c_op_jz   = 4'h8;
  localparam logic [3:0] c_op_ei   = 4'h9;
  localparam logic [3:0] c_op_di   = 4'hA;
  localparam logic [3:0] c_op_reti = 4'hB;
`ifdef SHIFT_OPS_EN
  localparam logic [3:0] c_op_shl  = 4'hC;
  localparam logic [3:0] c_op_shr  = 4'hD;
`endif
  localparam logic [3:0] c_op_nop  = 4'hE;
  localparam logic [3:0] c_op_halt = 4'hF;

  localparam logic [AW-1:0] c_pc_one  = AW'(1);
  localparam logic [AW-1:0] c_int_vec = AW'(INT_VEC);

  logic [7:0]    r_mem [2**AW];
  logic [DW-1:0] r_regs [4];
  logic [2:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_epc;
  logic [7:0]    r_ir;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_z;
  logic          r_c;
  logic          r_ie;
  logic          r_ei_block;

  logic [7:0]    w_mem_rd;
  logic [3:0]    w_op;
  logic [1:0]    w_rd;
  logic [1:0]    w_rs;
  logic [DW-1:0] w_rd_val;
  logic [DW-1:0] w_rs_val;
  logic [DW-1:0] w_imm;
  logic [AW-1:0] w_jaddr;
  logic [AW-1:0] w_pc_inc;
  logic          w_int_req;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_c;
  logic          w_alu_wr;
  logic          w_alu_zwr;
  logic          w_alu_cwr;
  logic          w_alu_zero;

  assign w_mem_rd   = r_mem[r_pc];
  assign w_op       = r_ir[7:4];
  assign w_rd       = r_ir[3:2];
  assign w_rs       = r_ir[1:0];
  assign w_rd_val   = r_regs[w_rd];
  assign w_rs_val   = r_regs[w_rs];
  assign w_imm      = DW'(w_mem_rd);
  assign w_jaddr    = AW'(w_mem_rd);
  assign w_pc_inc   = r_pc + c_pc_one;
  assign w_alu_zero = (w_alu_res == '0);

  // EI arms r_ei_block so the instruction after it completes before an interrupt is taken
  assign w_int_req  = r_ie & ~r_ei_block & interrupt;

  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_wr  = 1'b0;
    w_alu_zwr = 1'b0;
    w_alu_cwr = 1'b0;
    case (w_op)
      c_op_in: begin
        w_alu_res = in_data;
        w_alu_wr  = 1'b1;
      end
      c_op_mov: begin
        w_alu_res = w_rs_val;
        w_alu_wr  = 1'b1;
      end
      c_op_add: begin
        {w_alu_c, w_alu_res} = {1'b0, w_rd_val} + {1'b0, w_rs_val};
        w_alu_wr  = 1'b1;
        w_alu_zwr = 1'b1;
        w_alu_cwr = 1'b1;
      end
      c_op_sub: begin
        {w_alu_c, w_alu_res} = {1'b0, w_rd_val} - {1'b0, w_rs_val};
        w_alu_wr  = 1'b1;
        w_alu_zwr = 1'b1;
        w_alu_cwr = 1'b1;
      end
      c_op_and: begin
        w_alu_res = w_rd_val & w_rs_val;
        w_alu_wr  = 1'b1;
        w_alu_zwr = 1'b1;
      end
`ifdef SHIFT_OPS_EN
      c_op_shl: begin
        w_alu_res = {w_rd_val[DW-2:0], 1'b0};
        w_alu_c   = w_rd_val[DW-1];
        w_alu_wr  = 1'b1;
        w_alu_zwr = 1'b1;
        w_alu_cwr = 1'b1;
      end
      c_op_shr: begin
        w_alu_res = {1'b0, w_rd_val[DW-1:1]};
        w_alu_c   = w_rd_val[0];
        w_alu_wr  = 1'b1;
        w_alu_zwr = 1'b1;
        w_alu_cwr = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
      r_state     <= c_st_idle;
      r_pc        <= '0;
      r_epc       <= '0;
      r_ir        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_ie        <= 1'b0;
      r_ei_block  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (run) begin
            r_state <= c_st_fetch;
          end
        end
        c_st_fetch: begin
          if (!run) begin
            r_state <= c_st_idle;
          end else if (w_int_req) begin
            r_state <= c_st_int;
          end else begin
            r_ir       <= w_mem_rd;
            r_pc       <= w_pc_inc;
            r_ei_block <= 1'b0;
            r_state    <= c_st_exec;
          end
        end
        c_st_exec: begin
          r_state <= c_st_fetch;
          if (w_alu_wr) begin
            r_regs[w_rd] <= w_alu_res;
          end
          if (w_alu_zwr) begin
            r_z <= w_alu_zero;
          end
          if (w_alu_cwr) begin
            r_c <= w_alu_c;
          end
          case (w_op)
            c_op_out: begin
              r_out_data  <= w_rs_val;
              r_out_valid <= 1'b1;
            end
            c_op_ldi, c_op_jmp, c_op_jz: begin
              r_state <= c_st_opnd;
            end
            c_op_ei: begin
              r_ie       <= 1'b1;
              r_ei_block <= 1'b1;
            end
            c_op_di: begin
              r_ie <= 1'b0;
            end
            c_op_reti: begin
              r_pc <= r_epc;
              r_ie <= 1'b1;
            end
            c_op_halt: begin
              r_state <= c_st_halt;
            end
            c_op_nop: ;
            default: ;
          endcase
        end
        c_st_opnd: begin
          r_pc    <= w_pc_inc;
          r_state <= c_st_fetch;
          case (w_op)
            c_op_ldi: r_regs[w_rd] <= w_imm;
            c_op_jmp: r_pc <= w_jaddr;
            c_op_jz: begin
              if (r_z) begin
                r_pc <= w_jaddr;
              end
            end
            default: ;
          endcase
        end
        c_st_int: begin
          r_epc   <= r_pc;
          r_pc    <= c_int_vec;
          r_ie    <= 1'b0;
          r_state <= c_st_fetch;
        end
        c_st_halt: begin
          if (w_int_req) begin
            r_state <= c_st_int;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign int_ack   = (r_state == c_st_int);
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign halted    = (r_state == c_st_halt);
  assign zflag     = r_z;
  assign cflag     = r_c;

endmodule

`default_nettype wire

// File: tb/tb_param_micro_cpu.sv
// ============================================================================
// Module   : tb_param_micro_cpu
// Desc     : Directed self-checking bench for param_micro_cpu at DW=8 and DW=4.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_param_micro_cpu;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       interrupt;
  logic [7:0] in8;
  logic [3:0] in4;

  logic [7:0] out8;
  logic       ov8;
  logic       ack8;
  logic [3:0] pc8;
  logic [7:0] ir8;
  logic       halted8;
  logic       z8;
  logic       c8;

  logic [3:0] out4;
  logic       ov4;
  logic       ack4;
  logic [3:0] pc4;
  logic [7:0] ir4;
  logic       halted4;
  logic       z4;
  logic       c4;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ov8   = 0;
  int n_ack8  = 0;

  always #5 clk = ~clk;

  param_micro_cpu #(.DW(8), .AW(4), .INT_VEC(4'hE)) u8 (
    .clk(clk), .reset(reset), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .interrupt(interrupt),
    .in_data(in8), .out_data(out8), .out_valid(ov8), .int_ack(ack8),
    .pc(pc8), .ir(ir8), .halted(halted8), .zflag(z8), .cflag(c8)
  );

  param_micro_cpu #(.DW(4), .AW(4), .INT_VEC(4'hE)) u4 (
    .clk(clk), .reset(reset), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .interrupt(interrupt),
    .in_data(in4), .out_data(out4), .out_valid(ov4), .int_ack(ack4),
    .pc(pc4), .ir(ir4), .halted(halted4), .zflag(z4), .cflag(c4)
  );

  always @(negedge clk) begin
    if (ov8) n_ov8++;
    if (ack8) n_ack8++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  // Hold reset and fill memory with NOPs so stray fetches are harmless
  task automatic setup();
    reset     = 1'b0;
    run       = 1'b0;
    interrupt = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) wr(4'(i), 8'hE0);
  endtask

  task automatic start();
    reset = 1'b1;
    run   = 1'b1;
  endtask

  task automatic wait_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted8 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int base_ov;
    int base_ack;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    in8 = 8'h5A; in4 = 4'hB;

    // Basic program: LDI R0,5; LDI R1,3; ADD R0,R1; OUT R0; HALT
    setup();
    wr(4'h0, 8'h60); wr(4'h1, 8'h05); wr(4'h2, 8'h64); wr(4'h3, 8'h03);
    wr(4'h4, 8'h31); wr(4'h5, 8'h10); wr(4'h6, 8'hF0);
    chk("rst_pc",     32'(pc8), 32'h0);
    chk("rst_ir",     32'(ir8), 32'h0);
    chk("rst_out",    32'(out8), 32'h0);
    chk("rst_flags",  32'({ov8, ack8, halted8, z8, c8}), 32'h0);
    interrupt = 1'b1;
    base_ov = n_ov8; base_ack = n_ack8;
    start();
    wait_halt(40, cyc);
    chk("p1_halted",  32'(halted8), 32'h1);
    chk("p1_cycles",  32'(cyc), 32'd13);
    chk("p1_out",     32'(out8), 32'h8);
    chk("p1_ov_cnt",  32'(n_ov8 - base_ov), 32'h1);
    chk("p1_no_ack",  32'(n_ack8 - base_ack), 32'h0);
    chk("p1_zc",      32'({z8, c8}), 32'h0);
    chk("p1_pc",      32'(pc8), 32'h7);
    chk("p1_ir",      32'(ir8), 32'hF0);

    // ADD wraps to zero, then JZ taken to 0A
    setup();
    wr(4'h0, 8'h60); wr(4'h1, 8'hFF); wr(4'h2, 8'h64); wr(4'h3, 8'h01);
    wr(4'h4, 8'h31); wr(4'h5, 8'h80); wr(4'h6, 8'h0A); wr(4'h7, 8'hF0);
    wr(4'hA, 8'h10); wr(4'hB, 8'hF0);
    base_ov = n_ov8;
    start();
    wait_halt(40, cyc);
    chk("jz_t_out",   32'(out8), 32'h0);
    chk("jz_t_ov",    32'(n_ov8 - base_ov), 32'h1);
    chk("jz_t_z",     32'(z8), 32'h1);
    chk("jz_t_c",     32'(c8), 32'h1);
    chk("jz_t_pc",    32'(pc8), 32'hC);

    // AND clears Z but keeps C; JZ not taken skips its operand
    setup();
    wr(4'h0, 8'h60); wr(4'h1, 8'hFF); wr(4'h2, 8'h64); wr(4'h3, 8'h01);
    wr(4'h4, 8'h34); wr(4'h5, 8'h50); wr(4'h6, 8'h80); wr(4'h7, 8'h0E);
    wr(4'h8, 8'h10); wr(4'h9, 8'hF0); wr(4'hE, 8'hF0);
    start();
    wait_halt(40, cyc);
    chk("jz_n_out",   32'(out8), 32'hFF);
    chk("jz_n_zc",    32'({z8, c8}), 32'h1);
    chk("jz_n_pc",    32'(pc8), 32'hA);

    // LDI truncation and SUB borrow at both widths
    setup();
    wr(4'h0, 8'h60); wr(4'h1, 8'hA7); wr(4'h2, 8'h64); wr(4'h3, 8'h09);
    wr(4'h4, 8'h41); wr(4'h5, 8'h10); wr(4'h6, 8'hF0);
    start();
    wait_halt(40, cyc);
    chk("sub4_halt",  32'(halted4), 32'h1);
    chk("sub4_out",   32'(out4), 32'hE);
    chk("sub4_zc",    32'({z4, c4}), 32'h1);
    chk("sub8_out",   32'(out8), 32'h9E);
    chk("sub8_zc",    32'({z8, c8}), 32'h0);

    // IN then MOV then OUT
    setup();
    wr(4'h0, 8'h00); wr(4'h1, 8'h24); wr(4'h2, 8'h11); wr(4'h3, 8'hF0);
    start();
    wait_halt(40, cyc);
    chk("in8_out",    32'(out8), 32'h5A);
    chk("in4_out",    32'(out4), 32'hB);
    chk("in8_pc",     32'(pc8), 32'h4);

    // SHL of 0x81
    setup();
    wr(4'h0, 8'h60); wr(4'h1, 8'h81); wr(4'h2, 8'hC0); wr(4'h3, 8'h10);
    wr(4'h4, 8'hF0);
    start();
    wait_halt(40, cyc);
    chk("shl_cycles", 32'(cyc), 32'd10);
`ifdef SHIFT_OPS_EN
    chk("shl_out",    32'(out8), 32'h02);
    chk("shl_zc",     32'({z8, c8}), 32'h1);
`else
    chk("shl_out",    32'(out8), 32'h81);
    chk("shl_zc",     32'({z8, c8}), 32'h0);
`endif

    // EI shadow, interrupt entry, RETI return and re-enable
    setup();
    wr(4'h0, 8'h90); wr(4'h1, 8'hE0); wr(4'h2, 8'hE0); wr(4'h3, 8'hE0);
    wr(4'h4, 8'h70); wr(4'h5, 8'h03); wr(4'hE, 8'hB0);
    interrupt = 1'b1;
    start();
    cyc = 0;
    while (!ack8 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("int_ack",    32'(ack8), 32'h1);
    chk("int_cycles", 32'(cyc), 32'd6);
    chk("int_pc_pre", 32'(pc8), 32'h2);
    interrupt = 1'b0;
    tick();
    chk("int_vec_pc", 32'(pc8), 32'hE);
    chk("int_ack_1c", 32'(ack8), 32'h0);
    tick();
    tick();
    chk("reti_pc",    32'(pc8), 32'h2);
    interrupt = 1'b1;
    tick();
    chk("reti_ie",    32'(ack8), 32'h1);
    interrupt = 1'b0;
    tick();
    chk("reint_pc",   32'(pc8), 32'hE);

    // HALT ignores run, exits through INT when enabled
    setup();
    wr(4'h0, 8'h90); wr(4'h1, 8'hF0); wr(4'hE, 8'h10); wr(4'hF, 8'hF0);
    base_ov = n_ov8;
    start();
    wait_halt(40, cyc);
    chk("hlt_cycles", 32'(cyc), 32'd5);
    chk("hlt_pc",     32'(pc8), 32'h2);
    run = 1'b0;
    repeat (3) tick();
    chk("hlt_stay",   32'({halted8, ack8}), 32'h2);
    run = 1'b1;
    interrupt = 1'b1;
    tick();
    chk("hlt_ack",    32'({halted8, ack8}), 32'h1);
    interrupt = 1'b0;
    tick();
    chk("hlt_vec_pc", 32'(pc8), 32'hE);
    wait_halt(40, cyc);
    chk("hlt_wrap_pc", 32'(pc8), 32'h0);
    chk("hlt_ov",     32'(n_ov8 - base_ov), 32'h1);

    // Reset during OPND of JMP, memory retained afterwards
    setup();
    wr(4'h0, 8'h60); wr(4'h1, 8'hFF); wr(4'h2, 8'h64); wr(4'h3, 8'h01);
    wr(4'h4, 8'h31); wr(4'h5, 8'h11); wr(4'h6, 8'h70); wr(4'h7, 8'h0A);
    wr(4'hA, 8'hF0);
    start();
    repeat (13) tick();
    chk("mid_ir",     32'(ir8), 32'h70);
    chk("mid_pc",     32'(pc8), 32'h7);
    chk("mid_state",  32'({out8, z8, c8}), 32'h7);
    reset = 1'b0;
    tick();
    chk("mr_pc_ir",   32'({pc8, ir8}), 32'h0);
    chk("mr_out",     32'(out8), 32'h0);
    chk("mr_flags",   32'({ov8, ack8, halted8, z8, c8}), 32'h0);
    reset = 1'b1;
    wait_halt(40, cyc);
    chk("mr_rerun_out", 32'(out8), 32'h1);
    chk("mr_rerun_pc",  32'(pc8), 32'hB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
